// File: rtl/obi_cmd_mgr.sv
// OBI manager: converts a valid/ready command stream into single-word OBI
// transactions and returns in-order responses through a small credit-bounded FIFO.
module obi_cmd_mgr #(
    parameter int Depth = 2,
    parameter int CntW  = $clog2(Depth + 1)
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [3:0]  cmd_be_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,

    output logic        obi_req_o,
    output logic        obi_we_o,
    output logic [3:0]  obi_be_o,
    output logic [31:0] obi_addr_o,
    output logic [31:0] obi_wdata_o,
    input  logic        obi_gnt_i,
    input  logic        obi_rvalid_i,
    input  logic [31:0] obi_rdata_i,
    input  logic        obi_err_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,

    output logic        busy_o,
    output logic        unexp_rvalid_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    // Handshake convention: a transfer happens on a cycle where valid && ready
    // are both high at the rising clock edge; valid never waits on ready.

    logic              aval_q, aval_d;
    logic              a_we_q, a_we_d;
    logic [3:0]        a_be_q, a_be_d;
    logic [31:0]       a_addr_q, a_addr_d;
    logic [31:0]       a_wdata_q, a_wdata_d;

    logic [CntW-1:0]   credits_q, credits_d;
    logic [CntW-1:0]   outst_q, outst_d;
    logic [CntW-1:0]   fcnt_q, fcnt_d;
    logic [PtrW-1:0]   wptr_q, wptr_d;
    logic [PtrW-1:0]   rptr_q, rptr_d;
    logic [32:0]       mem_q [Depth];
    logic [32:0]       mem_d [Depth];

    logic              rsp_valid_q, rsp_valid_d;
    logic [32:0]       rsp_q, rsp_d;
    logic              unexp_q, unexp_d;

    logic              accept;
    logic              grant;
    logic              push;
    logic              pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(Depth - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    assign cmd_ready_o = (credits_q != '0) && (!aval_q || obi_gnt_i);
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign grant       = aval_q && obi_gnt_i;
    assign push        = obi_rvalid_i && (outst_q != '0);
    assign pop         = rsp_valid_q && rsp_ready_i;

    always_comb begin
        aval_d    = aval_q;
        a_we_d    = a_we_q;
        a_be_d    = a_be_q;
        a_addr_d  = a_addr_q;
        a_wdata_d = a_wdata_q;
        if (accept) begin
            aval_d    = 1'b1;
            a_we_d    = cmd_we_i;
            a_be_d    = cmd_be_i;
            a_addr_d  = cmd_addr_i;
            a_wdata_d = cmd_wdata_i;
        end else if (grant) begin
            aval_d = 1'b0;
        end
    end

    // Credits cover every slot from A-register through FIFO, so push never overflows.
    always_comb begin
        credits_d = credits_q;
        if (accept && !pop) begin
            credits_d = credits_q - CntW'(1);
        end else if (pop && !accept) begin
            credits_d = credits_q + CntW'(1);
        end

        outst_d = outst_q;
        if (grant && !push) begin
            outst_d = outst_q + CntW'(1);
        end else if (push && !grant) begin
            outst_d = outst_q - CntW'(1);
        end

        unexp_d = unexp_q | (obi_rvalid_i && (outst_q == '0));
    end

    // Next head is computed from next FIFO state so the response outputs are flops.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        fcnt_d = fcnt_q;
        if (push) begin
            mem_d[wptr_q] = {obi_rdata_i, obi_err_i};
            wptr_d        = ptr_inc(wptr_q);
        end
        if (pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
        if (push && !pop) begin
            fcnt_d = fcnt_q + CntW'(1);
        end else if (pop && !push) begin
            fcnt_d = fcnt_q - CntW'(1);
        end
        rsp_valid_d = (fcnt_d != '0);
        rsp_d       = mem_d[rptr_d];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aval_q      <= 1'b0;
            a_we_q      <= 1'b0;
            a_be_q      <= '0;
            a_addr_q    <= '0;
            a_wdata_q   <= '0;
            credits_q   <= CntW'(Depth);
            outst_q     <= '0;
            fcnt_q      <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            unexp_q     <= 1'b0;
        end else begin
            aval_q      <= aval_d;
            a_we_q      <= a_we_d;
            a_be_q      <= a_be_d;
            a_addr_q    <= a_addr_d;
            a_wdata_q   <= a_wdata_d;
            credits_q   <= credits_d;
            outst_q     <= outst_d;
            fcnt_q      <= fcnt_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
            unexp_q     <= unexp_d;
        end
    end

    assign obi_req_o      = aval_q;
    assign obi_we_o       = a_we_q;
    assign obi_be_o       = a_be_q;
    assign obi_addr_o     = a_addr_q;
    assign obi_wdata_o    = a_wdata_q;

    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_rdata_o    = rsp_q[32:1];
    assign rsp_err_o      = rsp_q[0];

    assign busy_o         = (credits_q != CntW'(Depth));
    assign unexp_rvalid_o = unexp_q;

endmodule
